// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state type for the UART command transmitter.
package uart_pkg;

    localparam int DBIT          = 8;
    localparam int SB_TICK       = 16;
    localparam int NUM_BYTES     = 3;
    localparam int TICKS_PER_BIT = 16;

    // Baud ticks in one 8N1 frame: start bit, DBIT data bits, stop period.
    localparam int FRAME_TICKS = (1 + DBIT) * TICKS_PER_BIT + SB_TICK;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_cmd_tx_baud_gen.sv
// rtl/uart_cmd_tx_baud_gen.sv - mod-DVSR baud divider with synchronous clear and enable.
module baud_gen #(
    parameter int DVSR     = 163,
    parameter int DVSR_BIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic s_tick
);

    logic [DVSR_BIT-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == DVSR_BIT'(DVSR - 1)) ? '0 : cnt + 1'b1;
        end
    end

    assign s_tick = en && (cnt == DVSR_BIT'(DVSR - 1));

endmodule

// File: rtl/uart_cmd_tx.sv
// rtl/uart_cmd_tx.sv - serialises a latched (a, b, op) command as three back-to-back 8N1 frames.
module uart_cmd_tx
    import uart_pkg::*;
#(
    parameter int DBIT     = uart_pkg::DBIT,
    parameter int SB_TICK  = uart_pkg::SB_TICK,
    parameter int DVSR     = 163,
    parameter int DVSR_BIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [DBIT-1:0] a,
    input  logic [DBIT-1:0] b,
    input  logic [DBIT-1:0] op,
    output logic            busy,
    output logic            done_tick,
    output logic            tx
);

    localparam int TICK_MAX = (SB_TICK > TICKS_PER_BIT) ? SB_TICK : TICKS_PER_BIT;
    localparam int TW       = $clog2(TICK_MAX);
    localparam int BW       = (DBIT > 1) ? $clog2(DBIT) : 1;

    tx_state_t       state;
    logic [TW-1:0]   tick;
    logic [BW-1:0]   nbit;
    logic [1:0]      idx;
    logic [DBIT-1:0] sreg [NUM_BYTES];
    logic            s_tick;
    logic            baud_clr;
    logic            baud_en;

    // Divider sits at zero in IDLE so the first start bit after acceptance is full length.
    assign baud_clr = (state == IDLE);
    assign baud_en  = (state != IDLE);

    baud_gen #(
        .DVSR     (DVSR),
        .DVSR_BIT (DVSR_BIT)
    ) u_baud_gen (
        .clk    (clk),
        .reset  (reset),
        .clr    (baud_clr),
        .en     (baud_en),
        .s_tick (s_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tick      <= '0;
            nbit      <= '0;
            idx       <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done_tick <= 1'b0;
        end else begin
            done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg[0] <= a;
                        sreg[1] <= b;
                        sreg[2] <= op;
                        idx     <= '0;
                        tick    <= '0;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (tick == TW'(TICKS_PER_BIT - 1)) begin
                            tick  <= '0;
                            nbit  <= '0;
                            tx    <= sreg[0][0];
                            state <= DATA;
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (tick == TW'(TICKS_PER_BIT - 1)) begin
                            tick <= '0;
                            if (nbit == BW'(DBIT - 1)) begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end else begin
                                // Bit 1 of the current byte is the next to go out; shift it down.
                                nbit    <= nbit + 1'b1;
                                tx      <= sreg[0][1];
                                sreg[0] <= sreg[0] >> 1;
                            end
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (tick == TW'(SB_TICK - 1)) begin
                            tick <= '0;
                            if (idx < 2'(NUM_BYTES - 1)) begin
                                idx     <= idx + 1'b1;
                                sreg[0] <= sreg[1];
                                sreg[1] <= sreg[2];
                                tx      <= 1'b0;
                                state   <= START;
                            end else begin
                                busy      <= 1'b0;
                                done_tick <= 1'b1;
                                state     <= IDLE;
                            end
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
